// File: rtl/pool2x2_ctrl.sv
// pool2x2_ctrl: 2x2 stride-2 max/average pooling sequencer for one raster-order pixel channel
module pool2x2_ctrl #(
  parameter int dataWidth = 16,
  parameter int ptype = 1,
  parameter int imgW = 8,
  parameter int imgH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [dataWidth-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [dataWidth-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);
  localparam int ColW = $clog2(imgW);
  localparam int RowW = $clog2(imgH);
  localparam int IdxW = (imgW > 2) ? $clog2(imgW / 2) : 1;
  localparam int SumW = dataWidth + 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t r_state;
  logic [ColW-1:0] r_col;
  logic [RowW-1:0] r_row;
  logic [dataWidth-1:0] r_pair;
  logic [SumW-1:0] r_lb [imgW/2];
  logic w_acc, w_last_col, w_last_row;
  logic [IdxW-1:0] w_idx;
  logic [SumW-1:0] w_a, w_b, w_h, w_lb, w_r;
  logic [dataWidth-1:0] w_res;
  assign in_ready = (r_state == RUN) && (!out_valid || out_ready);
  assign busy = r_state != IDLE;
  assign w_acc = in_valid && in_ready;
  assign w_last_col = r_col == ColW'(imgW - 1);
  assign w_last_row = r_row == RowW'(imgH - 1);
  assign w_idx = IdxW'(r_col >> 1);
  assign w_a = {2'b00, r_pair};
  assign w_b = {2'b00, in_data};
  assign w_h = (ptype != 0) ? ((w_a > w_b) ? w_a : w_b) : w_a + w_b;
  assign w_lb = r_lb[w_idx];
  assign w_r = (ptype != 0) ? ((w_lb > w_h) ? w_lb : w_h) : w_lb + w_h;
  assign w_res = (ptype != 0) ? w_r[dataWidth-1:0] : w_r[SumW-1:2];
  always_ff @(posedge clk)
    if (w_acc && r_col[0] && !r_row[0]) r_lb[w_idx] <= w_h;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_col <= '0;
      r_row <= '0;
      r_pair <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_ready) out_valid <= 1'b0;
      if (w_acc) begin
        r_col <= w_last_col ? '0 : r_col + 1'b1;
        if (w_last_col) r_row <= r_row + 1'b1;
        if (!r_col[0]) r_pair <= in_data;
        else if (r_row[0]) begin
          out_valid <= 1'b1;
          out_data <= w_res;
        end
        if (w_last_col && w_last_row) r_state <= DRAIN;
      end
      if (r_state == IDLE && start) begin
        r_state <= RUN;
        r_col <= '0;
        r_row <= '0;
      end
      if (r_state == DRAIN && (!out_valid || out_ready)) begin
        done <= 1'b1;
        r_state <= IDLE;
      end
    end
endmodule

// File: tb/tb_pool2x2_ctrl.sv
// tb_pool2x2_ctrl: randomized self-checking bench for pool2x2_ctrl (max 8x8 and average 4x4 instances)
module tb_pool2x2_ctrl;
  localparam int BUB = 1, RDY = 2, HOLD = 4, SPUR = 8, RST = 16;
  logic clk = 1'b0;
  logic rst;
  logic start [2], in_valid [2], in_ready [2], out_valid [2], out_ready [2], busy [2], done [2];
  logic [15:0] in_data [2], out_data [2];
  logic acc [2], pv [2], pr [2], pdone [2];
  logic [15:0] pd [2];
  int dones [2];
  logic [15:0] exp_q [$];
  logic [15:0] e;
  int act_k = 0;
  int n_chk = 0, n_fail = 0;
  int pix [64];
  bit seen;
  int hold;
  always #5 clk = ~clk;
  pool2x2_ctrl #(.dataWidth(16), .ptype(1), .imgW(8), .imgH(8)) u_max (
    .clk(clk), .rst(rst), .start(start[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .busy(busy[0]), .done(done[0])
  );
  pool2x2_ctrl #(.dataWidth(16), .ptype(0), .imgW(4), .imgH(4)) u_avg (
    .clk(clk), .rst(rst), .start(start[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .busy(busy[1]), .done(done[1])
  );
  function automatic int gw(input int k);
    return k == 0 ? 8 : 4;
  endfunction
  function automatic int gp(input int k);
    return k == 0 ? 1 : 0;
  endfunction
  function automatic logic [15:0] win(input int p, input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return p != 0 ? 16'(m) : 16'((a + b + c + d) / 4);
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, a, x);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic fill_ramp;
    for (int i = 0; i < 64; i++) pix[i] = i;
  endtask
  task automatic fill_rand;
    for (int i = 0; i < 64; i++) pix[i] = int'($urandom_range(0, 65535));
  endtask
  task automatic upd_ordy(input int k, input int mode);
    if ((mode & HOLD) != 0) begin
      if (!seen && out_valid[k]) begin
        seen = 1'b1;
        hold = 5;
      end
      out_ready[k] = hold == 0;
      if (hold > 0) hold--;
    end else out_ready[k] = ((mode & RDY) != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask
  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      acc[k] <= in_valid[k] && in_ready[k];
      if (!rst) begin
        if (pv[k] && !pr[k]) begin
          chk("hold_valid", out_valid[k], 1);
          chk("hold_data", out_data[k], pd[k]);
        end
        if (out_valid[k] && !out_ready[k]) chk("stall_in_ready", in_ready[k], 0);
        if (!busy[k]) chk("idle_in_ready", in_ready[k], 0);
        if (out_valid[k] && out_ready[k]) begin
          if (k != act_k || exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL extra_beat: dut %0d emitted %0d with no beat outstanding", k, out_data[k]);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data[k], e);
          end
        end
        if (done[k]) begin
          chk("done_no_pending", out_valid[k], 0);
          chk("done_all_beats", exp_q.size(), 0);
          chk("done_one_cycle", pdone[k], 0);
          dones[k] <= dones[k] + 1;
        end
      end
      pv[k] <= out_valid[k] && !rst;
      pr[k] <= out_ready[k];
      pd[k] <= out_data[k];
      pdone[k] <= done[k];
    end
  task automatic run_frame(input int k, input int mode);
    int w, n, idx, cyc, d0;
    bit first;
    w = gw(k);
    n = w * w;
    idx = 0;
    cyc = 0;
    seen = 1'b0;
    hold = 0;
    act_k = k;
    d0 = dones[k];
    for (int r = 0; r < w; r += 2)
      for (int c = 0; c < w; c += 2)
        exp_q.push_back(win(gp(k), pix[r*w+c], pix[r*w+c+1], pix[(r+1)*w+c], pix[(r+1)*w+c+1]));
    out_ready[k] = 1'b1;
    if ((mode & SPUR) != 0)
      for (int i = 0; i < 3; i++) begin
        in_valid[k] = 1'b1;
        in_data[k] = 16'($urandom);
        step;
      end
    in_valid[k] = 1'b0;
    start[k] = 1'b1;
    step;
    start[k] = 1'b0;
    chk("busy_run", busy[k], 1);
    while (idx < n && cyc < 4000) begin
      in_valid[k] = ((mode & BUB) != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data[k] = 16'(pix[idx]);
      start[k] = ((mode & SPUR) != 0) && idx == n / 2;
      upd_ordy(k, mode);
      step;
      cyc++;
      if (acc[k]) idx++;
      if ((mode & RST) != 0 && idx == 10) begin
        rst = 1'b1;
        step;
        chk("rst_out_valid", out_valid[k], 0);
        chk("rst_busy", busy[k], 0);
        chk("rst_in_ready", in_ready[k], 0);
        chk("rst_done", done[k], 0);
        rst = 1'b0;
        in_valid[k] = 1'b0;
        start[k] = 1'b0;
        exp_q.delete();
        step;
        chk("rst_no_done_pulse", dones[k] - d0, 0);
        return;
      end
    end
    chk("stream_in_time", idx, n);
    in_valid[k] = 1'b0;
    first = 1'b1;
    cyc = 0;
    while (dones[k] == d0 && cyc < 4000) begin
      start[k] = ((mode & SPUR) != 0) && first;
      first = 1'b0;
      upd_ordy(k, mode);
      step;
      cyc++;
    end
    start[k] = 1'b0;
    out_ready[k] = 1'b1;
    step;
    step;
    chk("done_count", dones[k] - d0, 1);
    chk("busy_after", busy[k], 0);
    chk("beats_left", exp_q.size(), 0);
  endtask
  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0;
      in_valid[k] = 1'b0;
      in_data[k] = '0;
      out_ready[k] = 1'b1;
      dones[k] = 0;
    end
    repeat (3) step;
    for (int k = 0; k < 2; k++) begin
      chk("reset_out_valid", out_valid[k], 0);
      chk("reset_out_data", out_data[k], 0);
      chk("reset_busy", busy[k], 0);
      chk("reset_done", done[k], 0);
      chk("reset_in_ready", in_ready[k], 0);
    end
    rst = 1'b0;
    step;
    chk("model_max_a", win(1, 1, 5, 4, 0), 5);
    chk("model_max_b", win(1, 2, 3, 9, 7), 9);
    chk("model_avg_trunc", win(0, 65535, 65535, 65535, 65532), 65534);
    fill_ramp;
    chk("model_ramp_first", win(1, pix[0], pix[1], pix[8], pix[9]), 9);
    chk("model_ramp_mid", win(1, pix[16], pix[17], pix[24], pix[25]), 25);
    chk("model_ramp_last", win(1, pix[54], pix[55], pix[62], pix[63]), 63);
    run_frame(0, 0);
    fill_ramp;
    run_frame(0, BUB);
    fill_rand;
    run_frame(0, HOLD);
    fill_rand;
    run_frame(0, BUB | RDY | SPUR);
    fill_ramp;
    run_frame(0, BUB | RST);
    fill_rand;
    run_frame(0, 0);
    fill_rand;
    pix[0] = 65535;
    pix[1] = 65535;
    pix[4] = 65535;
    pix[5] = 65532;
    run_frame(1, 0);
    fill_rand;
    run_frame(1, BUB | HOLD);
    fill_rand;
    run_frame(1, BUB | RDY | SPUR);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
